// File: rtl/timer_pkg.sv
// Shared definitions for the timer device: FSM encoding, register
// offsets, CTRL bit positions and MODE encodings.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] OFS_CTRL   = 2'd0;
  localparam logic [1:0] OFS_PRESET = 2'd1;
  localparam logic [1:0] OFS_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/timer_dev_if.sv
// CPU-side register bus of the timer device plus its interrupt line.
interface timer_dev_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  modport master (output addr, we, din, input dout, irq);
  modport slave  (input addr, we, din, output dout, irq);
endinterface

// File: rtl/timer_dev.sv
// Programmable down-counting timer with one-shot / auto-reload modes,
// a sticky pending flag and a maskable registered interrupt.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | stopped, COUNT holds, waiting for EN
// ST_LOAD | COUNT <= PRESET
// ST_CNT  | decrementing; reaching <=1 raises PEND
// ST_INT  | expiry: one-shot clears EN, auto-reload reloads
module timer_dev
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic        clk,
  input logic        rst,
  timer_dev_if.slave bus
);

  state_t           state_q, state_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] preset_q, preset_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pend_q, pend_d;
  logic             irq_q;
  logic             set_pend;
  logic             wr_ctrl, wr_preset, pend_clr;

  assign wr_ctrl   = bus.we && (bus.addr == OFS_CTRL);
  assign wr_preset = bus.we && (bus.addr == OFS_PRESET);

  // A CTRL write that only changes IM is a mask update and leaves PEND alone,
  // so software can unmask a pending expiry without losing it.
  assign pend_clr = wr_preset ||
                    (wr_ctrl && (bus.din[CTRL_MODE_HI:CTRL_EN] != ctrl_q[CTRL_MODE_HI:CTRL_EN]));

  // Next-state, counter, register-write and PEND logic.
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    pend_d   = pend_q;
    set_pend = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_q[CTRL_EN]) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q[CTRL_EN]) begin
          state_d = ST_IDLE;
        end else if (count_q > CNT_W'(1)) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          count_d  = '0;
          set_pend = 1'b1;
          state_d  = ST_INT;
        end
      end
      ST_INT: begin
        if (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD) begin
          pend_d  = 1'b0;
          state_d = ST_LOAD;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Software writes land after the hardware EN clear so they win.
    if (wr_ctrl)   ctrl_d   = bus.din[3:0];
    if (wr_preset) preset_d = bus.din[CNT_W-1:0];
    if (pend_clr)  pend_d   = 1'b0;
    // An expiry in the same cycle as a clearing write must not be lost.
    if (set_pend)  pend_d   = 1'b1;
  end

  // Read mux, combinational from the word address.
  always_comb begin
    bus.dout = '0;
    case (bus.addr)
      OFS_CTRL:   bus.dout = {28'b0, ctrl_q};
      OFS_PRESET: bus.dout = 32'(preset_q);
      OFS_COUNT:  bus.dout = 32'(count_q);
      default:    bus.dout = '0;
    endcase
  end

  assign bus.irq = irq_q;

  // State and register update; IRQ registered from the next PEND/IM so it
  // rises on the same edge that raises PEND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      irq_q    <= pend_d & ctrl_d[CTRL_IM];
    end
  end

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: directed scenarios plus random bus
// traffic, compared cycle by cycle against a timestamp-based reference.
module tb_timer_dev;

  logic clk = 1'b0;
  logic rst = 1'b1;

  timer_dev_if bus ();

  timer_dev #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: a run is described by the edge it was loaded on and the
  // edge it will expire on; COUNT is derived arithmetically from those.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count, m_load_val;
  bit          m_pend, m_irq, m_idle, m_run;
  int          m_e = 0;
  int          m_load_e, m_load_edge, m_fire_e, m_int_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_preset = '0; m_count = '0; m_load_val = '0;
    m_pend = 0; m_irq = 0; m_idle = 1; m_run = 0;
    m_load_e = -1; m_load_edge = -1; m_fire_e = -1; m_int_e = -1;
  endtask

  function automatic logic [31:0] mread(input logic [1:0] a);
    case (a)
      2'd0:    return {28'b0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step(input bit w, input logic [1:0] a, input logic [31:0] d);
    logic [3:0] ctrl_pre;
    bit set_p, clr_en;
    set_p = 0; clr_en = 0;
    ctrl_pre = m_ctrl;
    m_e++;
    if (m_load_e == m_e) begin
      m_load_e    = -1;
      m_load_val  = m_preset;
      m_count     = m_preset;
      m_load_edge = m_e;
      m_fire_e    = m_e + ((m_preset == 0) ? 1 : int'(m_preset));
      m_run       = 1;
    end else if (m_run) begin
      if (!m_ctrl[0]) begin
        m_run = 0; m_idle = 1;
      end else if (m_e == m_fire_e) begin
        m_count = 0; set_p = 1; m_run = 0; m_int_e = m_e + 1;
      end else begin
        m_count = m_load_val - 32'(m_e - m_load_edge);
      end
    end else if (m_int_e == m_e) begin
      m_int_e = -1;
      if (m_ctrl[2:1] == 2'b01) begin
        m_pend = 0; m_load_e = m_e + 1;
      end else begin
        clr_en = 1; m_idle = 1;
      end
    end else if (m_idle && m_ctrl[0]) begin
      m_idle = 0; m_load_e = m_e + 1;
    end
    if (clr_en) m_ctrl[0] = 1'b0;
    if (w && a == 2'd0) m_ctrl = d[3:0];
    if (w && a == 2'd1) m_preset = d;
    if (w && (a == 2'd1 || (a == 2'd0 && d[2:0] != ctrl_pre[2:0]))) m_pend = 0;
    if (set_p) m_pend = 1;
    m_irq = m_pend & m_ctrl[3];
  endtask

  task automatic cyc(input bit w, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.we = w; bus.addr = a; bus.din = d;
    #1 chk("dout_pre", bus.dout, mread(a));
    @(posedge clk);
    model_step(w, a, d);
    #1;
    chk("dout", bus.dout, mread(a));
    chk("irq", {31'b0, bus.irq}, {31'b0, m_irq});
  endtask

  task automatic rd_n(input logic [1:0] a, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, a, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1; bus.we = 1'b0;
    for (int a = 0; a < 4; a++) begin
      bus.addr = 2'(a);
      #1 chk("rst_dout", bus.dout, 32'h0);
    end
    chk("rst_irq", {31'b0, bus.irq}, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.we = 1'b0; bus.addr = 2'd0; bus.din = '0;
    model_reset();
    #1;
    for (int a = 0; a < 4; a++) begin
      bus.addr = 2'(a);
      #1 chk("init_dout", bus.dout, 32'h0);
    end
    chk("init_irq", {31'b0, bus.irq}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // One-shot, PRESET=3, IM=1.
    cyc(1, 2'd1, 32'd3);
    cyc(1, 2'd0, 32'h9);
    rd_n(2'd2, 6);
    rd_n(2'd0, 2);
    cyc(1, 2'd1, 32'd0);          // clears PEND

    // Auto-reload, PRESET=2.
    cyc(1, 2'd1, 32'd2);
    cyc(1, 2'd0, 32'hB);
    rd_n(2'd2, 14);
    cyc(1, 2'd0, 32'h0);

    // Disable mid-count, then re-enable.
    cyc(1, 2'd1, 32'd9);
    cyc(1, 2'd0, 32'h1);
    rd_n(2'd2, 6);
    cyc(1, 2'd0, 32'h0);
    rd_n(2'd2, 4);
    cyc(1, 2'd1, 32'd4);
    cyc(1, 2'd0, 32'h1);
    rd_n(2'd2, 8);

    // Masked pending, then unmask, then clear via PRESET write.
    cyc(1, 2'd1, 32'd1);
    cyc(1, 2'd0, 32'h1);
    rd_n(2'd0, 6);
    cyc(1, 2'd0, 32'h8);
    rd_n(2'd0, 2);
    cyc(1, 2'd1, 32'd5);
    rd_n(2'd0, 2);

    // PRESET=0 behaves as 1; PRESET change during count.
    cyc(1, 2'd1, 32'd0);
    cyc(1, 2'd0, 32'hB);
    rd_n(2'd2, 3);
    cyc(1, 2'd1, 32'd3);
    rd_n(2'd2, 10);
    cyc(1, 2'd0, 32'h0);

    // Writes to COUNT ignored, reserved reads zero.
    cyc(1, 2'd2, 32'hFFFF);
    rd_n(2'd2, 1);
    rd_n(2'd3, 1);

    // Asynchronous reset mid-count.
    cyc(1, 2'd1, 32'd10);
    cyc(1, 2'd0, 32'h9);
    rd_n(2'd2, 5);
    do_reset();
    cyc(1, 2'd1, 32'd2);
    cyc(1, 2'd0, 32'h9);
    rd_n(2'd2, 6);

    // Random bus traffic.
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [1:0] a;
      logic [31:0] d;
      r = int'($urandom_range(0, 99));
      a = 2'($urandom_range(0, 3));
      if (r < 2) begin
        do_reset();
      end else if (r < 16) begin
        if (a == 2'd0)      d = 32'($urandom_range(0, 15)) | 32'(($urandom_range(0, 3) != 0) ? 1 : 0);
        else if (a == 2'd1) d = 32'($urandom_range(0, 6));
        else                d = $urandom;
        cyc(1'b1, a, d);
      end else begin
        cyc(1'b0, a, 32'h0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 Parameter CNT_W, default 32, width of PRESET and COUNT registers (Din/Dout remain 32 bits, zero-extended).
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 Addr  input  2  word select (system address bits [3:2]): 00 CTRL, 01 PRESET, 10 COUNT, 11 reserved.
REQ-005 We  input  1  write strobe, sampled on rising clk.
REQ-006 Din  input  32  write data.
REQ-007 Dout  output  32  read data, combinational from Addr.
REQ-008 IRQ  output  1  interrupt request to CPU interrupt line 2, registered.

Function
REQ-009 CTRL[3:0] SHALL be: bit0 EN, bits2:1 MODE (00 one-shot, 01 auto-reload, 1x treated as one-shot), bit3 IM (interrupt mask, 1 = enabled); CTRL[31:4] read as 0.
REQ-010 Writes: We & Addr=00 -> CTRL <= Din[3:0]; We & Addr=01 -> PRESET <= Din[CNT_W-1:0]; Addr=10/11 writes ignored.
REQ-011 Reads: Addr=00 -> {28'b0, CTRL}; 01 -> PRESET; 10 -> COUNT; 11 -> 32'h0.
REQ-012 FSM states IDLE, LOAD, CNT, INT; plus sticky flag PEND.
REQ-013 IDLE: EN=1 -> LOAD; else stay; COUNT holds.
REQ-014 LOAD: COUNT <= PRESET; -> CNT.
REQ-015 CNT: EN=0 -> IDLE (COUNT holds); EN=1 and COUNT>1 -> COUNT-1, stay; EN=1 and COUNT<=1 -> COUNT <= 0, PEND <= 1, -> INT.
REQ-016 INT, one-shot: hardware clears EN; -> IDLE; PEND stays 1 until any write to CTRL or PRESET.
REQ-017 INT, auto-reload: PEND cleared after exactly one cycle; -> LOAD; EN unchanged.
REQ-018 IRQ SHALL equal registered (PEND & IM); changing IM masks/unmasks without affecting PEND.
REQ-019 Latency: write setting EN at edge E0 with PRESET=N>=1 -> IRQ high after edge E0+N+2; PRESET=0 behaves as N=1.
REQ-020 Auto-reload period SHALL be N+2 cycles, IRQ high one cycle per period.
REQ-021 PRESET write during CNT SHALL not alter COUNT; takes effect at next LOAD.
REQ-022 Same-cycle software CTRL write and hardware EN clear in INT: software write wins.
REQ-023 Same-cycle PEND set and PEND-clearing write: set wins.
REQ-024 COUNT SHALL never wrap below 0.

Reset
REQ-025 On rst: CTRL=0, PRESET=0, COUNT=0, PEND=0, IRQ=0, state IDLE, asynchronously, mid-count included.
REQ-026 First operation after rst deassertion SHALL be accepted on the next rising clk.

Structure
REQ-027 Shared package timer_pkg SHALL hold state encoding, register offsets (CTRL=0, PRESET=1, COUNT=2), CTRL bit positions and MODE encodings.
REQ-028 Single module; no sub-module (counter too small to split).

Verification
REQ-029 PRESET=3, write CTRL=4'b1001 at E0 -> COUNT 3,2,1,0 after E2..E5, IRQ=1 after E5, CTRL reads 4'b1000.
REQ-030 PRESET=2, CTRL=4'b1011 -> IRQ one-cycle pulses every 4 cycles, COUNT reloads to 2.
REQ-031 Counting with COUNT=5, write CTRL EN=0 -> next state IDLE, COUNT reads 5 and holds; re-enable -> reloads PRESET.
REQ-032 One-shot PEND=1, IM=0 -> IRQ=0; write IM=1 -> IRQ=1 next cycle; write PRESET -> IRQ=0 next cycle.
REQ-033 rst asserted mid-count (COUNT=7) -> all registers 0, IRQ=0 immediately, without clock edge.
REQ-034 Write Addr=10 with Din=32'hFFFF -> COUNT unchanged; read Addr=11 -> 32'h0.
